ifu_inst_queue: RTL and testbench

- Decoupling FIFO between the instruction fetch unit (icache front-end) and the decode stage.
- Absorbs fetch bursts while decode is stalled, so icache hits keep streaming instead of holding the AXI/cache pipeline.
- Carries per-instruction sideband: PC, fetch exception/mcause, and BTB predict bit.
- On flush (redirect, fence.i, trap) all queued entries are discarded.

---
 rtl/ifu_inst_queue_pkg.sv | 20 ++
 rtl/ifu_inst_queue.sv | 116 +++++++++++
 tb/tb_ifu_inst_queue.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ifu_inst_queue_pkg.sv
// ifu_inst_queue_pkg
//   Types and constants shared by the fetch/decode boundary.
//   fetch_entry_t is the per-instruction record that moves from the IFU, through
//   the instruction queue, and into the IDU. It is declared at the default XLEN
//   so that IFU and IDU code can use it directly.
package ifu_inst_queue_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned MCAUSE_W      = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] inst;
    logic [XLEN_DEFAULT-1:0] pc;
    logic                    exception;
    logic [MCAUSE_W-1:0]     mcause;
    logic                    predict;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_inst_queue.sv
// ifu_inst_queue
//   Show-ahead FIFO that decouples the instruction fetch unit from decode.
//   Each entry carries the instruction together with its PC, fetch fault
//   flag/cause and BTB predict bit. A flush or reset empties the queue in one
//   cycle.
//
// Ports
//   i_clock, i_reset      core clock, synchronous active-high reset
//   i_flush               discard all entries (redirect, fence.i, trap)
//   i_valid / o_ready     upstream handshake; o_ready is purely registered
//   i_inst, i_pc,
//   i_exception,
//   i_mcause, i_predict   entry payload from the IFU
//   o_valid / i_ready     downstream handshake to decode
//   o_inst, o_pc,
//   o_exception,
//   o_mcause, o_predict   head entry payload (valid only while o_valid)
//   o_count               occupancy, for perf counters
module ifu_inst_queue
  import ifu_inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [XLEN-1:0]         i_inst,
  input  logic [XLEN-1:0]         i_pc,
  input  logic                    i_exception,
  input  logic [MCAUSE_W-1:0]     i_mcause,
  input  logic                    i_predict,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [XLEN-1:0]         o_inst,
  output logic [XLEN-1:0]         o_pc,
  output logic                    o_exception,
  output logic [MCAUSE_W-1:0]     o_mcause,
  output logic                    o_predict,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Same field layout as fetch_entry_t, but sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0]     inst;
    logic [XLEN-1:0]     pc;
    logic                exception;
    logic [MCAUSE_W-1:0] mcause;
    logic                predict;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          entry_in;
  entry_t          head;
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  // Ready depends only on the count register: a full queue refuses a push
  // even if decode pops in the same cycle, which keeps i_ready off the
  // upstream timing path.
  assign o_ready = (count != FULL);
  assign o_valid = (count != '0);

  assign push = i_valid && o_ready && !i_flush;
  assign pop  = o_valid && i_ready && !i_flush;

  always_comb begin
    entry_in           = '0;
    entry_in.inst      = i_inst;
    entry_in.pc        = i_pc;
    entry_in.exception = i_exception;
    entry_in.mcause    = i_mcause;
    entry_in.predict   = i_predict;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale contents are hidden because count gates
  // o_valid. A write that lands during reset is harmless for the same reason.
  always_ff @(posedge i_clock) begin
    if (push) mem[wp] <= entry_in;
  end

  // Show-ahead: the head entry is presented directly from the array.
  assign head        = mem[rp];
  assign o_inst      = head.inst;
  assign o_pc        = head.pc;
  assign o_exception = head.exception;
  assign o_mcause    = head.mcause;
  assign o_predict   = head.predict;
  assign o_count     = count;

endmodule

// File: tb/tb_ifu_inst_queue.sv
module tb_ifu_inst_queue;
  import ifu_inst_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_inst, in_pc;
  logic        in_exc, in_pred;
  logic [3:0]  in_mc;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;
  logic        out_exc, out_pred;
  logic [3:0]  out_mc;
  logic [2:0]  out_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;
  fetch_entry_t sb[$];

  always #5 clk = ~clk;

  ifu_inst_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .i_clock(clk), .i_reset(rst), .i_flush(flush),
    .i_valid(in_valid), .o_ready(out_ready),
    .i_inst(in_inst), .i_pc(in_pc), .i_exception(in_exc),
    .i_mcause(in_mc), .i_predict(in_pred),
    .o_valid(out_valid), .i_ready(in_ready),
    .o_inst(out_inst), .o_pc(out_pc), .o_exception(out_exc),
    .o_mcause(out_mc), .o_predict(out_pred), .o_count(out_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] pc, input logic exc,
                                      input logic [3:0] mc, input logic pred);
    fetch_entry_t e;
    e.inst = pc ^ 32'h5A5A_0013;
    e.pc = pc;
    e.exception = exc;
    e.mcause = mc;
    e.predict = pred;
    return e;
  endfunction

  task automatic drive(input fetch_entry_t e, input logic v);
    in_valid = v;
    in_inst = e.inst;
    in_pc = e.pc;
    in_exc = e.exception;
    in_mc = e.mcause;
    in_pred = e.predict;
  endtask

  // One clock: at the falling edge compare the DUT against the model, apply
  // the handshake the model predicts, then return 1 time unit after the rise.
  task automatic tick();
    bit push_ok, pop_ok;
    fetch_entry_t exp_e, cur;
    @(negedge clk);
    if (chk_en) begin
      chk("count", 64'(out_count), 64'(sb.size()));
      chk("o_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("o_ready", 64'(out_ready), 64'(sb.size() != DEPTH));
      chk("count_le_depth", 64'(out_count <= 3'(DEPTH)), 64'd1);
    end
    if (rst || flush) begin
      sb.delete();
    end else begin
      pop_ok  = (sb.size() != 0) && in_ready;
      push_ok = in_valid && (sb.size() != DEPTH);
      cur.inst = in_inst; cur.pc = in_pc; cur.exception = in_exc;
      cur.mcause = in_mc; cur.predict = in_pred;
      if (pop_ok) begin
        exp_e = sb.pop_front();
        chk("head_inst", 64'(out_inst), 64'(exp_e.inst));
        chk("head_pc", 64'(out_pc), 64'(exp_e.pc));
        chk("head_exc", 64'(out_exc), 64'(exp_e.exception));
        chk("head_mcause", 64'(out_mc), 64'(exp_e.mcause));
        chk("head_predict", 64'(out_pred), 64'(exp_e.predict));
      end
      if (push_ok) sb.push_back(cur);
    end
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  task automatic drain();
    drive(mk(32'h0, 1'b0, 4'h0, 1'b0), 1'b0);
    in_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    in_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_ready = 1'b0;
    drive(mk(32'h0, 1'b0, 4'h0, 1'b0), 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(out_ready), 64'd1);
    chk("rst_count", 64'(out_count), 64'd0);

    // Fill with decode stalled
    for (int k = 0; k < 4; k++) begin
      drive(mk(32'h8000_0000 + 32'(4 * k), 1'b0, 4'h0, 1'b0), 1'b1);
      tick();
    end
    drive(mk(32'h0, 1'b0, 4'h0, 1'b0), 1'b0);
    chk("fill_ready", 64'(out_ready), 64'd0);
    chk("fill_count", 64'(out_count), 64'd4);
    chk("fill_head_pc", 64'(out_pc), 64'h8000_0000);

    // Drain in order
    in_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", 64'(out_pc), 64'h8000_0000 + 64'(4 * k));
      tick();
    end
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(out_count), 64'd0);

    // Streaming push+pop, pointers wrap several times
    for (int k = 0; k < 20; k++) begin
      drive(mk(32'h8000_1000 + 32'(4 * k), k[0], 4'(k), k[1]), 1'b1);
      tick();
      chk("stream_count", 64'(out_count), 64'd1);
    end
    drain();

    // Full queue: pop happens, push is refused in the same cycle
    for (int k = 0; k < 4; k++) begin
      drive(mk(32'h8000_2000 + 32'(4 * k), 1'b0, 4'h0, 1'b0), 1'b1);
      tick();
    end
    drive(mk(32'h8000_2010, 1'b0, 4'h0, 1'b1), 1'b1);
    in_ready = 1'b1;
    tick();
    chk("full_nopass_count", 64'(out_count), 64'd3);
    in_ready = 1'b0;
    tick();
    chk("full_refill_count", 64'(out_count), 64'd4);
    drain();

    // Flush with concurrent push and pop request
    for (int k = 0; k < 3; k++) begin
      drive(mk(32'h8000_3000 + 32'(4 * k), 1'b0, 4'h0, 1'b0), 1'b1);
      tick();
    end
    drive(mk(32'h8000_0100, 1'b0, 4'h0, 1'b0), 1'b1);
    flush = 1'b1; in_ready = 1'b1;
    tick();
    flush = 1'b0; in_ready = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_count", 64'(out_count), 64'd0);
    chk("flush_ready", 64'(out_ready), 64'd1);
    drive(mk(32'h8000_0200, 1'b0, 4'h0, 1'b0), 1'b1);
    tick();
    chk("post_flush_head", 64'(out_pc), 64'h8000_0200);
    drain();

    // Sideband travels with its instruction
    drive(mk(32'h8000_0010, 1'b1, 4'h1, 1'b0), 1'b1);
    tick();
    drive(mk(32'h8000_0014, 1'b0, 4'h0, 1'b1), 1'b1);
    tick();
    drive(mk(32'h0, 1'b0, 4'h0, 1'b0), 1'b0);
    chk("sb_exc0", 64'(out_exc), 64'd1);
    chk("sb_mc0", 64'(out_mc), 64'd1);
    chk("sb_pred0", 64'(out_pred), 64'd0);
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    chk("sb_exc1", 64'(out_exc), 64'd0);
    chk("sb_pred1", 64'(out_pred), 64'd1);
    drain();

    // Reset mid-operation with a push in flight
    for (int k = 0; k < 2; k++) begin
      drive(mk(32'h8000_4000 + 32'(4 * k), 1'b0, 4'h0, 1'b0), 1'b1);
      tick();
    end
    chk("pre_rst_count", 64'(out_count), 64'd2);
    drive(mk(32'h8000_4008, 1'b0, 4'h0, 1'b0), 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(mk(32'h0, 1'b0, 4'h0, 1'b0), 1'b0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(out_ready), 64'd1);
    chk("mid_rst_count", 64'(out_count), 64'd0);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
